// File: rtl/game_pkg.sv
// game_pkg: shared direction and movement-FSM state types for the game grid logic.
package game_pkg;
  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT} dir_t;
  typedef enum logic [1:0] {IDLE, PEND, APPLY, WAIT_REL} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stability counter producing a debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, diff, done;
  // Count only while the synchronised input disagrees with the accepted level.
  always_comb begin
    diff = sync_q[1] ^ level_q;
    done = diff && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d = (diff && !done) ? cnt_q + 1'b1 : '0;
    level_d = done ? sync_q[1] : level_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q <= cnt_d;
      level_q <= level_d;
    end
  end
  assign level_o = level_q;
endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: debounced, arbitrated, frame-synchronous player grid movement.
// Define PLAYER_WRAP_EN to make edge moves wrap instead of saturate.
module player_move_ctrl
  import game_pkg::*;
#(
  parameter int GRID_W = 2,
  parameter int GRID_H = 2,
  parameter int X_START = 0,
  parameter int Y_START = 0,
  parameter int DEBOUNCE_CYCLES = 250000,
  localparam int XW = (GRID_W > 2) ? $clog2(GRID_W) : 1,
  localparam int YW = (GRID_H > 2) ? $clog2(GRID_H) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_right,
  input  logic btn_left,
  input  logic frame_tick,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic moved,
  output dir_t move_dir
);
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
  logic [3:0] btn, lvl, lvl_q, press;
  state_t state_q, state_d;
  dir_t dir_q, dir_d, press_dir;
  logic [XW-1:0] pos_x_q, pos_x_d, x_inc, x_dec;
  logic [YW-1:0] pos_y_q, pos_y_d, y_inc, y_dec;
  logic apply;
  assign btn = {btn_up, btn_down, btn_right, btn_left};
  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .btn_i(btn[i]),
      .level_o(lvl[i])
    );
  end
  always_comb begin
    press = lvl & ~lvl_q;
    press_dir = press[3] ? DIR_UP : press[2] ? DIR_DOWN : press[1] ? DIR_RIGHT :
                press[0] ? DIR_LEFT : DIR_NONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    unique case (state_q)
      IDLE: if (press_dir != DIR_NONE) begin
        state_d = PEND;
        dir_d = press_dir;
      end
      PEND: state_d = frame_tick ? APPLY : PEND;
      APPLY: state_d = WAIT_REL;
      WAIT_REL: state_d = (lvl == 4'b0) ? IDLE : WAIT_REL;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    moved = state_q == APPLY;
    move_dir = moved ? dir_q : DIR_NONE;
  end
  // Position is registered on the tick so it changes in the same cycle moved is high.
  always_comb begin
    apply = (state_q == PEND) && frame_tick;
`ifdef PLAYER_WRAP_EN
    x_inc = (pos_x_q == XMAX) ? '0 : pos_x_q + 1'b1;
    x_dec = (pos_x_q == '0) ? XMAX : pos_x_q - 1'b1;
    y_inc = (pos_y_q == YMAX) ? '0 : pos_y_q + 1'b1;
    y_dec = (pos_y_q == '0) ? YMAX : pos_y_q - 1'b1;
`else
    x_inc = (pos_x_q == XMAX) ? pos_x_q : pos_x_q + 1'b1;
    x_dec = (pos_x_q == '0) ? pos_x_q : pos_x_q - 1'b1;
    y_inc = (pos_y_q == YMAX) ? pos_y_q : pos_y_q + 1'b1;
    y_dec = (pos_y_q == '0) ? pos_y_q : pos_y_q - 1'b1;
`endif
    pos_x_d = !apply ? pos_x_q : (dir_q == DIR_RIGHT) ? x_inc : (dir_q == DIR_LEFT) ? x_dec : pos_x_q;
    pos_y_d = !apply ? pos_y_q : (dir_q == DIR_UP) ? y_inc : (dir_q == DIR_DOWN) ? y_dec : pos_y_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_NONE;
      lvl_q <= '0;
      pos_x_q <= XW'(X_START);
      pos_y_q <= YW'(Y_START);
    end else begin
      dir_q <= dir_d;
      lvl_q <= lvl;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end
  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: directed scoreboard bench for player_move_ctrl on a 2x2 grid.
module tb_player_move_ctrl;
  import game_pkg::*;
  logic clk = 0, rst_n = 0, frame_tick = 0;
  logic btn_up = 0, btn_down = 0, btn_right = 0, btn_left = 0;
  logic pos_x, pos_y, moved;
  dir_t move_dir;
  typedef struct {int x; int y; dir_t d;} mv_t;
  mv_t exp_q[$];
  int n_chk = 0, n_fail = 0, ex = 0, ey = 0;

  player_move_ctrl #(.GRID_W(2), .GRID_H(2), .X_START(0), .Y_START(0), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_right(btn_right),
    .btn_left(btn_left), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
    .moved(moved), .move_dir(move_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && moved) begin
      if (exp_q.size() == 0) chk("unexpected_move", int'(moved), 0);
      else begin
        mv_t m;
        m = exp_q.pop_front();
        chk("move_x", int'(pos_x), m.x);
        chk("move_y", int'(pos_y), m.y);
        chk("move_dir", int'(move_dir), int'(m.d));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int exp_mv);
    @(posedge clk); #1 frame_tick = 1;
    @(posedge clk); #1 frame_tick = 0;
    chk("moved_after_tick", int'(moved), exp_mv);
    cyc(2);
  endtask

  task automatic mv(input dir_t d);
    mv_t m;
`ifdef PLAYER_WRAP_EN
    if (d == DIR_UP) ey = (ey + 1) % 2;
    if (d == DIR_DOWN) ey = (ey + 1) % 2;
    if (d == DIR_RIGHT) ex = (ex + 1) % 2;
    if (d == DIR_LEFT) ex = (ex + 1) % 2;
`else
    if (d == DIR_UP && ey < 1) ey++;
    if (d == DIR_DOWN && ey > 0) ey--;
    if (d == DIR_RIGHT && ex < 1) ex++;
    if (d == DIR_LEFT && ex > 0) ex--;
`endif
    m.x = ex; m.y = ey; m.d = d;
    exp_q.push_back(m);
  endtask

  initial begin
    cyc(3);
    rst_n = 1;
    cyc(2);
    chk("reset_x", int'(pos_x), 0);
    chk("reset_y", int'(pos_y), 0);
    chk("reset_moved", int'(moved), 0);
    chk("reset_dir", int'(move_dir), int'(DIR_NONE));
    tick(0);
    tick(0);
    chk("idle_x", int'(pos_x), 0);
    // right from (0,0)
    btn_right = 1; cyc(10);
    mv(DIR_RIGHT); tick(1);
    chk("right_x", int'(pos_x), ex);
    btn_right = 0; cyc(10);
    // right at the right edge
    btn_right = 1; cyc(10);
    mv(DIR_RIGHT); tick(1);
    chk("edge_x", int'(pos_x), ex);
    btn_right = 0; cyc(10);
    // up and left together: up wins, holding gives no repeat
    btn_up = 1; btn_left = 1; cyc(10);
    mv(DIR_UP); tick(1);
    tick(0);
    tick(0);
    chk("arb_x", int'(pos_x), ex);
    chk("arb_y", int'(pos_y), ey);
    btn_up = 0; btn_left = 0; cyc(10);
    // bouncing button never settles
    repeat (10) begin btn_up = ~btn_up; cyc(2); end
    cyc(10);
    tick(0);
    tick(0);
    chk("bounce_y", int'(pos_y), ey);
    // down twice, second hits bottom edge
    btn_down = 1; cyc(10);
    mv(DIR_DOWN); tick(1);
    btn_down = 0; cyc(10);
    btn_down = 1; cyc(10);
    mv(DIR_DOWN); tick(1);
    chk("down_edge_y", int'(pos_y), ey);
    btn_down = 0; cyc(10);
    btn_left = 1; cyc(10);
    mv(DIR_LEFT); tick(1);
    chk("left_x", int'(pos_x), ex);
    btn_left = 0; cyc(10);
    // reset with a pending move
    btn_down = 1; cyc(10);
    rst_n = 0; cyc(2);
    btn_down = 0; cyc(2);
    rst_n = 1; ex = 0; ey = 0;
    cyc(2);
    chk("rst_mid_x", int'(pos_x), ex);
    chk("rst_mid_y", int'(pos_y), ey);
    tick(0);
    chk("rst_mid_moved", int'(moved), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
